sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter ORDER_DEPTH, default 2, is the maximum number of accepted requests still awaiting data_ok; legal values are 1..4.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  instruction-fetch master request bundle, SRAM-like.
REQ-005 inst_sram_addr_ok/data_ok  out  1/1  request-accepted and response-valid to the fetch master.
REQ-006 inst_sram_rdata  out  32  response data to the fetch master.
REQ-007 data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  load/store master request bundle, SRAM-like.
REQ-008 data_sram_addr_ok/data_ok  out  1/1  request-accepted and response-valid to the load/store master.
REQ-009 data_sram_rdata  out  32  response data to the load/store master.
REQ-010 mem_req/wr/size/wstrb/addr/wdata  out  1/1/2/4/32/32  shared slave request bundle.
REQ-011 mem_addr_ok/data_ok  in  1/1  slave accept and response; the slave returns responses in request order.
REQ-012 mem_rdata  in  32  slave response data.

Function
REQ-013 The grant FSM SHALL have the states IDLE, LOCK_INST and LOCK_DATA.
REQ-014 In IDLE, the arbiter SHALL select data when data_sram_req=1, else inst when inst_sram_req=1, else none; the selection is combinational in that cycle.
REQ-015 If the selected request is presented and not accepted, the FSM SHALL move to LOCK_<selected> and hold that grant until mem_req & mem_addr_ok; it then returns to IDLE.
REQ-016 While locked, a higher-priority request SHALL NOT preempt the grant; this keeps the mem_* bundle stable.
REQ-017 mem_req SHALL equal (granted master's req) & ~order_full; mem_wr/size/wstrb/addr/wdata SHALL mux from the granted master, or be zero when none is granted.
REQ-018 The granted master's addr_ok SHALL equal mem_req & mem_addr_ok; the non-granted master's addr_ok SHALL be 0.
REQ-019 On mem_req & mem_addr_ok, the source id (0 = inst, 1 = data) SHALL be pushed into an in-order FIFO of depth ORDER_DEPTH.
REQ-020 On mem_data_ok with the FIFO non-empty, the head id SHALL be popped and only that master's data_ok asserted in the same cycle.
REQ-021 mem_rdata SHALL drive both inst_sram_rdata and data_sram_rdata unmodified.
REQ-022 The arbiter SHALL add zero latency: req->mem_req, mem_addr_ok->addr_ok and mem_data_ok->data_ok are all combinational.
REQ-023 Push and pop in the same cycle SHALL leave the count unchanged and retain FIFO order.
REQ-024 When full (count = ORDER_DEPTH), mem_req SHALL be 0; a pop in that cycle SHALL NOT enable a push in the same cycle.
REQ-025 mem_data_ok while the FIFO is empty SHALL be ignored: both data_ok outputs are 0 and the count stays 0.
REQ-026 The counter and pointers SHALL wrap modulo ORDER_DEPTH; the count width is clog2(ORDER_DEPTH+1).

Reset
REQ-027 When resetn=0 at a rising edge, the FSM SHALL go to IDLE and the FIFO to empty (count 0, pointers 0).
REQ-028 During reset, mem_req, both addr_ok and both data_ok SHALL be 0.
REQ-029 Reset applied mid-transaction SHALL discard all outstanding ids; later mem_data_ok for those ids follows REQ-025.

Structure
REQ-030 The shared package SHALL hold the SRC_INST/SRC_DATA id constants, the grant state encoding and the default ORDER_DEPTH.
REQ-031 The order FIFO SHALL be the sub-module arb_order_fifo, with push/pop/id_in/id_out/full/empty ports; all other logic is in the top module.

Verification
REQ-032 Only inst_sram_req=1, addr 0x1c000000, with mem_addr_ok=1 -> mem_addr=0x1c000000 and inst_sram_addr_ok=1 in the same cycle; a data_ok 3 cycles later -> inst_sram_data_ok=1 and data_sram_data_ok=0.
REQ-033 inst and data req rise together, data addr 0x00001000 -> data is granted first; inst is accepted on the next accept cycle; responses route data then inst.
REQ-034 inst req pending with mem_addr_ok=0 for 4 cycles and data req rising at cycle 2 -> mem_addr stays the inst address until accepted (no preemption).
REQ-035 ORDER_DEPTH=2 and two accepts with no data_ok -> mem_req=0 on the third request; one mem_data_ok -> the third is issued the next cycle.
REQ-036 Push and pop in the same cycle with count=1 -> count stays 1; a spurious mem_data_ok while empty -> no data_ok is asserted.
REQ-037 resetn=0 with 2 outstanding -> after release, count=0, FSM=IDLE, and mem_data_ok produces no response.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the two-master SRAM-like request arbiter:
// source ids, grant FSM encoding and default order-FIFO depth.
package sram_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int DEFAULT_ORDER_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } grant_state_e;

endpackage

// File: rtl/sram_req_arbiter_order_fifo.sv
// In-order FIFO of 1-bit source ids for requests accepted by the slave but
// not yet answered; the head id steers each response to its master.
module arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic id_in,
  output logic id_out,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ids_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign id_out  = ids_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Id storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) ids_q[wr_ptr_q] <= id_in;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Fixed-priority (data over inst) arbiter sharing one SRAM-like slave between
// the fetch and load/store masters, with zero added latency on every path.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int ORDER_DEPTH = DEFAULT_ORDER_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  grant_state_e state_q;
  logic         grant_inst;
  logic         grant_data;
  logic         granted_req;
  logic         accept;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         head_id;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      LOCK_INST: grant_inst = 1'b1;
      LOCK_DATA: grant_data = 1'b1;
      default: begin
        if (data_sram_req)      grant_data = 1'b1;
        else if (inst_sram_req) grant_inst = 1'b1;
      end
    endcase
  end

  assign granted_req = (grant_inst & inst_sram_req) | (grant_data & data_sram_req);
  assign mem_req     = resetn & granted_req & ~fifo_full;
  assign accept      = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_data) begin
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else if (grant_inst) begin
      mem_wr    = inst_sram_wr;
      mem_size  = inst_sram_size;
      mem_wstrb = inst_sram_wstrb;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end
  end

  assign inst_sram_addr_ok = accept & grant_inst;
  assign data_sram_addr_ok = accept & grant_data;

  // Responses with nothing outstanding are dropped rather than routed.
  assign fifo_pop          = resetn & mem_data_ok & ~fifo_empty;
  assign inst_sram_data_ok = fifo_pop & (head_id == SRC_INST);
  assign data_sram_data_ok = fifo_pop & (head_id == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  // Once a request is shown but stalled, the grant is held so the slave
  // sees a stable bundle until it accepts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (granted_req && !accept) state_q <= grant_data ? LOCK_DATA : LOCK_INST;
        end
        LOCK_INST, LOCK_DATA: begin
          if (accept) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  arb_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (fifo_pop),
    .id_in  (grant_data ? SRC_DATA : SRC_INST),
    .id_out (head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed scenario bench for sram_req_arbiter; a queue of expected source
// ids is filled on each request and drained as responses come back.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic exp_q [$];
  logic exp_id;

  always #5 clk = ~clk;

  sram_req_arbiter #(.ORDER_DEPTH(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'h0; data_sram_addr = '0; data_sram_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  // Drives one slave response and checks its routing against the queue head.
  task automatic respond(input logic [31:0] rdata, input string tag);
    mem_data_ok = 1; mem_rdata = rdata;
    #1;
    exp_id = exp_q.pop_front();
    n_checks++;
    if (inst_sram_data_ok !== (exp_id == SRC_INST) || data_sram_data_ok !== (exp_id == SRC_DATA)) begin
      n_fails++;
      $display("FAIL %s route: inst_data_ok=%b data_data_ok=%b expected id=%0d", tag,
               inst_sram_data_ok, data_sram_data_ok, exp_id);
    end
    n_checks++;
    if (inst_sram_rdata !== rdata || data_sram_rdata !== rdata) begin
      n_fails++;
      $display("FAIL %s rdata: got %h/%h expected %h", tag, inst_sram_rdata, data_sram_rdata, rdata);
    end
    $display("resp %s: id=%0d rdata=%h", tag, exp_id, rdata);
    tick();
    mem_data_ok = 0;
  endtask

  task automatic test_reset();
    resetn = 0; clear_inputs();
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    tick();
    #1;
    n_checks++;
    if ({mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b required 00000",
               {mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    @(negedge clk);
    clear_inputs(); resetn = 1;
    tick();
    n_checks++;
    if (dut.state_q !== IDLE || dut.u_order_fifo.count_q !== 2'd0) begin
      n_fails++;
      $display("FAIL reset_state: state=%0d count=%0d required 0/0", dut.state_q, dut.u_order_fifo.count_q);
    end
    $display("reset: done");
  endtask

  task automatic test_single_inst();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; mem_addr_ok = 1;
    #1;
    exp_q.push_back(SRC_INST);
    n_checks++;
    if (mem_req !== 1 || mem_addr !== 32'h1c00_0000 || inst_sram_addr_ok !== 1 || data_sram_addr_ok !== 0) begin
      n_fails++;
      $display("FAIL single_accept: req=%b addr=%h iok=%b dok=%b required 1/1c000000/1/0",
               mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
    end
    $display("req single_inst: addr=%h", mem_addr);
    tick();
    clear_inputs();
    tick(); tick();
    respond(32'hdead_beef, "single_inst");
  endtask

  task automatic test_priority();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0040;
    data_sram_req = 1; data_sram_addr = 32'h0000_1000; data_sram_wr = 1;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'h1234_5678; mem_addr_ok = 1;
    #1;
    exp_q.push_back(SRC_DATA);
    n_checks++;
    if (mem_addr !== 32'h0000_1000 || mem_wr !== 1 || mem_wdata !== 32'h1234_5678 ||
        data_sram_addr_ok !== 1 || inst_sram_addr_ok !== 0) begin
      n_fails++;
      $display("FAIL prio_data_first: addr=%h wr=%b wdata=%h dok=%b iok=%b required 00001000/1/12345678/1/0",
               mem_addr, mem_wr, mem_wdata, data_sram_addr_ok, inst_sram_addr_ok);
    end
    $display("req prio data: addr=%h", mem_addr);
    tick();
    data_sram_req = 0; data_sram_wr = 0;
    #1;
    exp_q.push_back(SRC_INST);
    n_checks++;
    if (mem_addr !== 32'h1c00_0040 || mem_wr !== 0 || inst_sram_addr_ok !== 1 || data_sram_addr_ok !== 0) begin
      n_fails++;
      $display("FAIL prio_inst_next: addr=%h wr=%b iok=%b dok=%b required 1c000040/0/1/0",
               mem_addr, mem_wr, inst_sram_addr_ok, data_sram_addr_ok);
    end
    $display("req prio inst: addr=%h", mem_addr);
    tick();
    clear_inputs();
    respond(32'haaaa_0001, "prio_first");
    respond(32'hbbbb_0002, "prio_second");
  endtask

  task automatic test_no_preempt();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100; mem_addr_ok = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        data_sram_req = 1; data_sram_addr = 32'h0000_2000;
      end
      #1;
      n_checks++;
      if (mem_req !== 1 || mem_addr !== 32'h1c00_0100 || data_sram_addr_ok !== 0) begin
        n_fails++;
        $display("FAIL hold_cycle%0d: req=%b addr=%h dok=%b required 1/1c000100/0", c, mem_req, mem_addr, data_sram_addr_ok);
      end
      $display("hold cycle %0d: addr=%h", c, mem_addr);
      tick();
    end
    mem_addr_ok = 1;
    #1;
    exp_q.push_back(SRC_INST);
    n_checks++;
    if (mem_addr !== 32'h1c00_0100 || inst_sram_addr_ok !== 1 || data_sram_addr_ok !== 0) begin
      n_fails++;
      $display("FAIL hold_accept: addr=%h iok=%b dok=%b required 1c000100/1/0", mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
    end
    tick();
    inst_sram_req = 0;
    #1;
    exp_q.push_back(SRC_DATA);
    n_checks++;
    if (mem_addr !== 32'h0000_2000 || data_sram_addr_ok !== 1) begin
      n_fails++;
      $display("FAIL hold_then_data: addr=%h dok=%b required 00002000/1", mem_addr, data_sram_addr_ok);
    end
    $display("req after hold: addr=%h", mem_addr);
    tick();
    clear_inputs();
    respond(32'h0000_0111, "hold_inst");
    respond(32'h0000_0222, "hold_data");
  endtask

  task automatic test_full();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0200; mem_addr_ok = 1;
    exp_q.push_back(SRC_INST);
    tick();
    inst_sram_req = 0; data_sram_req = 1; data_sram_addr = 32'h0000_3000;
    exp_q.push_back(SRC_DATA);
    tick();
    data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0208;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (mem_req !== 0 || inst_sram_addr_ok !== 0) begin
        n_fails++;
        $display("FAIL full_block%0d: req=%b iok=%b required 0/0", c, mem_req, inst_sram_addr_ok);
      end
      $display("full cycle %0d: mem_req=%b", c, mem_req);
      tick();
    end
    mem_data_ok = 1; mem_rdata = 32'hf00d_0001;
    #1;
    exp_id = exp_q.pop_front();
    n_checks++;
    if (inst_sram_data_ok !== (exp_id == SRC_INST) || data_sram_data_ok !== (exp_id == SRC_DATA) || mem_req !== 0) begin
      n_fails++;
      $display("FAIL full_pop: iok=%b dok=%b req=%b required %b/%b/0",
               inst_sram_data_ok, data_sram_data_ok, mem_req, exp_id == SRC_INST, exp_id == SRC_DATA);
    end
    tick();
    mem_data_ok = 0;
    #1;
    exp_q.push_back(SRC_INST);
    n_checks++;
    if (mem_req !== 1 || mem_addr !== 32'h1c00_0208 || inst_sram_addr_ok !== 1) begin
      n_fails++;
      $display("FAIL full_reissue: req=%b addr=%h iok=%b required 1/1c000208/1", mem_req, mem_addr, inst_sram_addr_ok);
    end
    $display("req after full: addr=%h", mem_addr);
    tick();
    clear_inputs();
    respond(32'hf00d_0002, "full_data");
    respond(32'hf00d_0003, "full_inst");
  endtask

  task automatic test_back_to_back();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0300; mem_addr_ok = 1;
    exp_q.push_back(SRC_INST);
    tick();
    inst_sram_req = 0; data_sram_req = 1; data_sram_addr = 32'h0000_4000;
    mem_data_ok = 1; mem_rdata = 32'hcafe_0001;
    #1;
    exp_id = exp_q.pop_front();
    exp_q.push_back(SRC_DATA);
    n_checks++;
    if (data_sram_addr_ok !== 1 || inst_sram_data_ok !== (exp_id == SRC_INST) || data_sram_data_ok !== (exp_id == SRC_DATA)) begin
      n_fails++;
      $display("FAIL pushpop_same: dok_addr=%b i_data_ok=%b d_data_ok=%b required 1/1/0",
               data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (dut.u_order_fifo.count_q !== 2'd1) begin
      n_fails++;
      $display("FAIL pushpop_count: got %0d required 1", dut.u_order_fifo.count_q);
    end
    $display("pushpop: count=%0d", dut.u_order_fifo.count_q);
    respond(32'hcafe_0002, "pushpop_data");
    mem_data_ok = 1; mem_rdata = 32'h5badbad5;
    #1;
    n_checks++;
    if (inst_sram_data_ok !== 0 || data_sram_data_ok !== 0) begin
      n_fails++;
      $display("FAIL spurious_resp: iok=%b dok=%b required 0/0", inst_sram_data_ok, data_sram_data_ok);
    end
    tick();
    mem_data_ok = 0;
    n_checks++;
    if (dut.u_order_fifo.count_q !== 2'd0) begin
      n_fails++;
      $display("FAIL spurious_count: got %0d required 0", dut.u_order_fifo.count_q);
    end
    $display("spurious: count=%0d", dut.u_order_fifo.count_q);
  endtask

  task automatic test_reset_mid();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0400; mem_addr_ok = 1;
    tick();
    inst_sram_req = 0; data_sram_req = 1; data_sram_addr = 32'h0000_5000;
    tick();
    data_sram_req = 0; inst_sram_req = 1;
    resetn = 0; mem_data_ok = 1;
    #1;
    n_checks++;
    if ({mem_req, inst_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0) begin
      n_fails++;
      $display("FAIL midreset_outputs: got %b required 0000",
               {mem_req, inst_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    tick();
    clear_inputs(); resetn = 1;
    exp_q.delete();
    tick();
    n_checks++;
    if (dut.state_q !== IDLE || dut.u_order_fifo.count_q !== 2'd0) begin
      n_fails++;
      $display("FAIL midreset_state: state=%0d count=%0d required 0/0", dut.state_q, dut.u_order_fifo.count_q);
    end
    mem_data_ok = 1;
    #1;
    n_checks++;
    if (inst_sram_data_ok !== 0 || data_sram_data_ok !== 0) begin
      n_fails++;
      $display("FAIL midreset_resp: iok=%b dok=%b required 0/0", inst_sram_data_ok, data_sram_data_ok);
    end
    $display("midreset: stale response dropped");
    tick();
    mem_data_ok = 0;
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    @(negedge clk);
    test_reset();
    test_single_inst();
    test_priority();
    test_no_preempt();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
